// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-port ALU arbiter.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/xor/slt with {N,Z,C,V} flags and illegal-op error.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              err
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            carry;
    logic            ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Carry out of a + ~b + 1 is 1 when no borrow occurs (a >= b unsigned).
    assign diff = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[MSB:0];
                carry  = sum[DATA_W];
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = diff[MSB:0];
                carry  = diff[DATA_W];
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: err = 1'b1;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[MSB];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin (or fixed) grant
// and a one-entry registered response slot per port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [3:0]        rsp0_flags,
    output logic [TAG_W-1:0]  rsp0_tag,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [3:0]        rsp1_flags,
    output logic [TAG_W-1:0]  rsp1_tag,
    output logic              rsp1_err
);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               sel;
    logic               last_gnt;

    logic [NUM_REQ-1:0] slot_valid;
    logic [NUM_REQ-1:0] slot_err;
    logic [DATA_W-1:0]  slot_result [NUM_REQ];
    logic [3:0]         slot_flags  [NUM_REQ];
    logic [TAG_W-1:0]   slot_tag    [NUM_REQ];

    logic [DATA_W-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]         alu_op;
    logic [3:0]         alu_flags;
    logic               alu_err;
    logic [TAG_W-1:0]   gnt_tag;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A full slot may be refilled in the same cycle it is drained.
    always_comb begin
        elig  = req_valid & (~slot_valid | rsp_ready);
        grant = '0;
        if (elig == 2'b11) begin
            sel = (FIXED_PRI != 0) ? 1'b0 : ~last_gnt;
        end else begin
            sel = elig[1];
        end
        if (|elig) begin
            grant[sel] = 1'b1;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign alu_a   = sel ? req1_a   : req0_a;
    assign alu_b   = sel ? req1_b   : req0_b;
    assign alu_op  = sel ? req1_op  : req0_op;
    assign gnt_tag = sel ? req1_tag : req0_tag;

    alu #(.DATA_W(DATA_W)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .flags  (alu_flags),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= 1'b1;
            slot_valid <= '0;
            slot_err   <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                slot_result[i] <= '0;
                slot_flags[i]  <= '0;
                slot_tag[i]    <= '0;
            end
        end else begin
            if (|grant) begin
                last_gnt <= sel;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    slot_valid[i]  <= 1'b1;
                    slot_result[i] <= alu_result;
                    slot_flags[i]  <= alu_flags;
                    slot_tag[i]    <= gnt_tag;
                    slot_err[i]    <= alu_err;
                end else if (rsp_ready[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp0_valid  = slot_valid[0];
    assign rsp0_result = slot_result[0];
    assign rsp0_flags  = slot_flags[0];
    assign rsp0_tag    = slot_tag[0];
    assign rsp0_err    = slot_err[0];
    assign rsp1_valid  = slot_valid[1];
    assign rsp1_result = slot_result[1];
    assign rsp1_flags  = slot_flags[1];
    assign rsp1_tag    = slot_tag[1];
    assign rsp1_err    = slot_err[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a behavioural model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  v  = '0;
    logic [1:0]  rr = '0;
    logic [31:0] a  [2];
    logic [31:0] b  [2];
    logic [2:0]  op [2];
    logic [3:0]  tg [2];

    logic [1:0]  rdy, o_v, o_err;
    logic [31:0] o_res [2];
    logic [3:0]  o_fl  [2];
    logic [3:0]  o_tag [2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        bit        v;
        bit [31:0] res;
        bit [3:0]  fl;
        bit [3:0]  tag;
        bit        err;
    } slot_t;
    slot_t m [2];
    int    last;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .TAG_W(4), .FIXED_PRI(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_a(a[0]), .req0_b(b[0]),
        .req0_op(op[0]), .req0_tag(tg[0]),
        .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_a(a[1]), .req1_b(b[1]),
        .req1_op(op[1]), .req1_tag(tg[1]),
        .rsp0_valid(o_v[0]), .rsp0_ready(rr[0]), .rsp0_result(o_res[0]),
        .rsp0_flags(o_fl[0]), .rsp0_tag(o_tag[0]), .rsp0_err(o_err[0]),
        .rsp1_valid(o_v[1]), .rsp1_ready(rr[1]), .rsp1_result(o_res[1]),
        .rsp1_flags(o_fl[1]), .rsp1_tag(o_tag[1]), .rsp1_err(o_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU from arithmetic on wide signed/unsigned integers.
    task automatic exp_alu(input bit [31:0] x, input bit [31:0] y, input bit [2:0] o,
                           output bit [31:0] r, output bit [3:0] f, output bit e);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        longint hi = 2147483647;
        longint lo = -hi - 1;
        longint s;
        bit c = 0, ov = 0;
        e = 0;
        r = 0;
        case (o)
            3'd0: begin r = x + y; c = (ux + uy) > 64'hFFFFFFFF; s = sx + sy; ov = (s > hi) || (s < lo); end
            3'd1: begin r = x - y; c = (ux >= uy); s = sx - sy; ov = (s > hi) || (s < lo); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = (sx < sy) ? 32'd1 : 32'd0;
            default: e = 1;
        endcase
        f = {r[31], (r == 0), c, ov};
    endtask

    task automatic model_reset();
        m[0] = '0;
        m[1] = '0;
        last = 1;
    endtask

    // One clock: check grant and responses at the negedge, commit the model after the posedge.
    task automatic cycle(output bit g0, output bit g1);
        bit e [2];
        bit g [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e[i] = v[i] && (!m[i].v || rr[i]);
            g[i] = 0;
        end
        if (e[0] && e[1]) g[(last == 0) ? 1 : 0] = 1;
        else if (e[0])    g[0] = 1;
        else if (e[1])    g[1] = 1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(g[i]));
            check($sformatf("rspvalid%0d", i), 32'(o_v[i]), 32'(m[i].v));
            if (m[i].v) begin
                check($sformatf("result%0d", i), o_res[i], m[i].res);
                check($sformatf("flags%0d", i), 32'(o_fl[i]), 32'(m[i].fl));
                check($sformatf("tag%0d", i), 32'(o_tag[i]), 32'(m[i].tag));
                check($sformatf("err%0d", i), 32'(o_err[i]), 32'(m[i].err));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                m[i].v = 1;
                exp_alu(a[i], b[i], op[i], m[i].res, m[i].fl, m[i].err);
                m[i].tag = tg[i];
                last = i;
            end else if (rr[i]) begin
                m[i].v = 0;
            end
        end
        g0 = g[0];
        g1 = g[1];
    endtask

    task automatic offer(input int p, input bit [31:0] x, input bit [31:0] y,
                         input bit [2:0] o, input bit [3:0] t);
        v[p]  = 1'b1;
        a[p]  = x;
        b[p]  = y;
        op[p] = o;
        tg[p] = t;
    endtask

    function automatic bit [31:0] rnd_operand();
        bit [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
        return $urandom;
    endfunction

    task automatic idle(input int n);
        bit g0, g1;
        v  = '0;
        rr = 2'b11;
        for (int i = 0; i < n; i++) cycle(g0, g1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g0, g1;
        bit [31:0] held_res;
        bit prev_g0;
        bit got;
        for (int i = 0; i < 2; i++) begin
            a[i] = '0; b[i] = '0; op[i] = '0; tg[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_valid%0d", i), 32'(o_v[i]), 32'd0);
            check($sformatf("reset_result%0d", i), o_res[i], 32'd0);
            check($sformatf("reset_flags%0d", i), 32'(o_fl[i]), 32'd0);
            check($sformatf("reset_tag%0d", i), 32'(o_tag[i]), 32'd0);
            check($sformatf("reset_err%0d", i), 32'(o_err[i]), 32'd0);
        end
        rst_n = 1'b1;
        rr = 2'b11;

        // Both ports offer 5+7 together.
        offer(0, 5, 7, 3'd0, 4'h1);
        offer(1, 5, 7, 3'd0, 4'h2);
        cycle(g0, g1);
        check("first_grant0", 32'(g0), 32'd1);
        check("first_grant1", 32'(g1), 32'd0);
        v[0] = 1'b0;
        cycle(g0, g1);
        check("second_grant1", 32'(g1), 32'd1);
        check("add_rsp0", o_res[0], 32'd12);
        check("add_flags0", 32'(o_fl[0]), 32'h0);
        v[1] = 1'b0;
        cycle(g0, g1);
        check("add_rsp1", o_res[1], 32'd12);
        idle(2);

        // sub 3-3 with tag 0xA
        offer(0, 3, 3, 3'd1, 4'hA);
        cycle(g0, g1);
        v[0] = 1'b0;
        check("sub_valid", 32'(o_v[0]), 32'd1);
        check("sub_result", o_res[0], 32'd0);
        check("sub_flags", 32'(o_fl[0]), 32'b0110);
        check("sub_tag", 32'(o_tag[0]), 32'hA);
        idle(1);

        // signed overflow on add
        offer(0, 32'h7FFFFFFF, 32'h1, 3'd0, 4'h3);
        cycle(g0, g1);
        v[0] = 1'b0;
        check("ovf_result", o_res[0], 32'h80000000);
        check("ovf_flags", 32'(o_fl[0]), 32'b1001);
        idle(1);

        // Port 0 stalled by a full slot while port 1 streams.
        rr[0] = 1'b0;
        offer(0, 32'd100, 32'd23, 3'd0, 4'h4);
        cycle(g0, g1);
        held_res = o_res[0];
        offer(0, 32'd9, 32'd9, 3'd4, 4'h5);
        offer(1, rnd_operand(), rnd_operand(), 3'($urandom_range(5)), 4'($urandom));
        for (int k = 0; k < 4; k++) begin
            cycle(g0, g1);
            check("stall_grant0", 32'(g0), 32'd0);
            check("stall_grant1", 32'(g1), 32'd1);
            check("stall_hold", o_res[0], held_res);
            offer(1, rnd_operand(), rnd_operand(), 3'($urandom_range(5)), 4'($urandom));
        end
        v[1] = 1'b0;
        rr[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            cycle(g0, g1);
            got = g0;
        end
        check("stall_release", 32'(got), 32'd1);
        idle(2);

        // Back-to-back on port 0: 4 ops in 4 cycles, in order.
        for (int k = 0; k < 4; k++) begin
            offer(0, 32'(1000 * (k + 1)), 32'(k), 3'd0, 4'(k));
            cycle(g0, g1);
            check("b2b_grant", 32'(g0), 32'd1);
            check("b2b_result", o_res[0], 32'(1000 * (k + 1) + k));
        end
        idle(2);

        // Both saturating: grants alternate.
        offer(0, 1, 2, 3'd2, 4'h0);
        offer(1, 3, 4, 3'd3, 4'h1);
        cycle(g0, g1);
        prev_g0 = g0;
        for (int k = 0; k < 5; k++) begin
            cycle(g0, g1);
            check("alt_onehot", 32'(g0 ^ g1), 32'd1);
            check("alt_toggle", 32'(g0), 32'(!prev_g0));
            prev_g0 = g0;
        end
        idle(2);

        // Illegal op
        offer(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 4'h7);
        cycle(g0, g1);
        v[0] = 1'b0;
        check("illegal_consumed", 32'(g0), 32'd1);
        check("illegal_result", o_res[0], 32'd0);
        check("illegal_flags", 32'(o_fl[0]), 32'b0100);
        check("illegal_err", 32'(o_err[0]), 32'd1);
        idle(1);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < 2; p++) begin
                rr[p] = ($urandom_range(9) < 7);
            end
            cycle(g0, g1);
            for (int p = 0; p < 2; p++) begin
                if ((p == 0 ? g0 : g1) || !v[p]) begin
                    if ($urandom_range(9) < 7)
                        offer(p, rnd_operand(), rnd_operand(), 3'($urandom_range(7)), 4'($urandom));
                    else
                        v[p] = 1'b0;
                end
            end
        end
        idle(2);

        // Async reset while rsp1 is full.
        rr[1] = 1'b0;
        offer(1, 32'd40, 32'd2, 3'd0, 4'h9);
        cycle(g0, g1);
        check("pre_reset_valid1", 32'(o_v[1]), 32'd1);
        offer(0, 32'd1, 32'd1, 3'd0, 4'h1);
        offer(1, 32'd2, 32'd2, 3'd0, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid1", 32'(o_v[1]), 32'd0);
        model_reset();
        rr = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(g0, g1);
        check("post_reset_grant0", 32'(g0), 32'd1);
        cycle(g0, g1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
